if_stage: RTL and testbench

//  Fetch stage of the 5-stage MIPS pipeline: owns the PC register, issues instruction-memory

---
 rtl/cpu_defs_pkg.sv | 16 +
 rtl/if_stage_if_id_reg.sv | 50 +++++
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset PC, bubble instruction word and fetch FSM encoding.
package cpu_defs;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: a load captures a real instruction, a bubble inserts
// the NOP word and records the PC (and a possible fetch fault) of the slot.
import cpu_defs::*;

module if_id_reg #(
    parameter logic [31:0] NOP = cpu_defs::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        adel_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        adel_o
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        adel_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= 32'h0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
            adel_q  <= 1'b0;
        end else if (bubble_i) begin
            pc_q    <= pc_i;
            instr_q <= NOP;
            valid_q <= 1'b0;
            adel_q  <= adel_i;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;
    assign adel_o  = adel_q;

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: PC register, imem req/ack handshake, skid buffer for data
// that arrives while decode is stalled, and the IF/ID pipeline register.
import cpu_defs::*;

module if_stage #(
    parameter logic [31:0] PC_RESET  = cpu_defs::PC_RESET,
    parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] npc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_f_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] instr_d_o,
    output logic        valid_d_o,
    output logic        adel_d_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    logic         started_q;

    logic         aligned;
    logic         ifid_load;
    logic         ifid_bubble;
    logic         ifid_adel;
    logic [31:0]  ifid_pc;
    logic [31:0]  ifid_instr;

    assign aligned = is_aligned(fetch_pc_q);

    // started_q keeps the request low for the first cycle after reset release,
    // so a stale ack from an abandoned request cannot be mistaken for data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= FETCH;
            fetch_pc_q   <= PC_RESET;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
            started_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            started_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        imem_req_o   = 1'b0;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_adel    = 1'b0;
        ifid_pc      = fetch_pc_q;
        ifid_instr   = imem_rdata_i;

        if (started_q) begin
            case (state_q)
                FETCH: begin
                    if (aligned) begin
                        imem_req_o = 1'b1;
                        if (imem_ack_i && !stall_i) begin
                            ifid_load  = 1'b1;
                            fetch_pc_d = npc_i;
                        end else if (imem_ack_i) begin
                            skid_instr_d = imem_rdata_i;
                            skid_pc_d    = fetch_pc_q;
                            state_d      = HOLD;
                        end else if (!stall_i) begin
                            ifid_bubble = 1'b1;
                        end
                    end else if (!stall_i) begin
                        // Misaligned PC: never reaches memory, faults in decode instead.
                        ifid_bubble = 1'b1;
                        ifid_adel   = 1'b1;
                        fetch_pc_d  = npc_i;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        ifid_load  = 1'b1;
                        ifid_pc    = skid_pc_q;
                        ifid_instr = skid_instr_q;
                        fetch_pc_d = npc_i;
                        state_d    = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    if_id_reg #(
        .NOP(NOP_INSTR)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (ifid_load),
        .bubble_i(ifid_bubble),
        .pc_i    (ifid_pc),
        .instr_i (ifid_instr),
        .adel_i  (ifid_adel),
        .pc_o    (pc_d_o),
        .instr_o (instr_d_o),
        .valid_o (valid_d_o),
        .adel_o  (adel_d_o)
    );

    assign imem_addr_o = fetch_pc_q;
    assign pc_f_o      = fetch_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by a long random
// ack/stall run checked against a transaction-level model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] PC_RST = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] npc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        adel_d;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc;
    logic [31:0] e_pcd;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_adel;

    if_stage dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .npc_i       (npc),
        .stall_i     (stall),
        .imem_req_o  (imem_req),
        .imem_addr_o (imem_addr),
        .imem_ack_i  (imem_ack),
        .imem_rdata_i(imem_rdata),
        .pc_f_o      (pc_f),
        .pc_d_o      (pc_d),
        .instr_d_o   (instr_d),
        .valid_d_o   (valid_d),
        .adel_d_o    (adel_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b1; stall = 1'b0;
        npc = $urandom; imem_rdata = $urandom;
        repeat (3) @(negedge clk);
        checks++; if (pc_f !== PC_RST) begin errors++; $display("[TB] FAIL rst_pc_f got %h want %h", pc_f, PC_RST); end
        checks++; if (pc_d !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc_d got %h want 0", pc_d); end
        checks++; if (instr_d !== NOP) begin errors++; $display("[TB] FAIL rst_instr got %h want %h", instr_d, NOP); end
        checks++; if (valid_d !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", valid_d); end
        checks++; if (adel_d !== 1'b0) begin errors++; $display("[TB] FAIL rst_adel got %b want 0", adel_d); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %b want 0", imem_req); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rel_req got %b want 0", imem_req); end
        @(negedge clk);
        checks++; if (valid_d !== 1'b0) begin errors++; $display("[TB] FAIL rel_ack_ignored valid got %b want 0", valid_d); end
        checks++; if (pc_f !== PC_RST) begin errors++; $display("[TB] FAIL rel_pc_f got %h want %h", pc_f, PC_RST); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== PC_RST) begin errors++; $display("[TB] FAIL rel_req req %b addr %h want 1 %h", imem_req, imem_addr, PC_RST); end
        exp_pc = PC_RST; e_pcd = 32'h0; e_instr = NOP; e_valid = 1'b0; e_adel = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] word;
        for (int i = 0; i < 4; i++) begin
            word = $urandom;
            imem_ack = 1'b1; stall = 1'b0; imem_rdata = word; npc = exp_pc + 32'd4;
            @(negedge clk);
            e_pcd = exp_pc; e_instr = word; e_valid = 1'b1; e_adel = 1'b0;
            exp_pc = exp_pc + 32'd4;
            checks++; if (pc_f !== exp_pc) begin errors++; $display("[TB] FAIL seq_pc_f got %h want %h", pc_f, exp_pc); end
            checks++; if (pc_d !== e_pcd) begin errors++; $display("[TB] FAIL seq_pc_d got %h want %h", pc_d, e_pcd); end
            checks++; if (instr_d !== e_instr || valid_d !== 1'b1) begin errors++; $display("[TB] FAIL seq_instr got %h/%b want %h/1", instr_d, valid_d, e_instr); end
            checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL seq_req got %b want 1", imem_req); end
        end
    endtask

    task automatic test_ack_delay();
        logic [31:0] a;
        logic [31:0] word;
        a = exp_pc;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b0; stall = 1'b0; imem_rdata = $urandom; npc = $urandom;
            @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("[TB] FAIL delay_req req %b addr %h want 1 %h", imem_req, imem_addr, a); end
            checks++; if (pc_f !== a) begin errors++; $display("[TB] FAIL delay_pc_f got %h want %h", pc_f, a); end
            checks++; if (valid_d !== 1'b0 || instr_d !== NOP || pc_d !== a) begin errors++; $display("[TB] FAIL delay_bubble got %b %h %h want 0 %h %h", valid_d, instr_d, pc_d, NOP, a); end
        end
        word = $urandom;
        imem_ack = 1'b1; imem_rdata = word; npc = a + 32'd4;
        @(negedge clk);
        exp_pc = a + 32'd4; e_pcd = a; e_instr = word; e_valid = 1'b1; e_adel = 1'b0;
        checks++; if (pc_d !== a || instr_d !== word || valid_d !== 1'b1) begin errors++; $display("[TB] FAIL delay_deliver got %h %h %b want %h %h 1", pc_d, instr_d, valid_d, a, word); end
        checks++; if (pc_f !== exp_pc) begin errors++; $display("[TB] FAIL delay_advance got %h want %h", pc_f, exp_pc); end
    endtask

    task automatic test_ack_stall();
        logic [31:0] b;
        logic [31:0] word;
        b = exp_pc; word = $urandom;
        imem_ack = 1'b1; stall = 1'b1; imem_rdata = word; npc = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_req got %b want 0", imem_req); end
            checks++; if (pc_f !== b) begin errors++; $display("[TB] FAIL hold_pc_f got %h want %h", pc_f, b); end
            checks++; if (pc_d !== e_pcd || instr_d !== e_instr || valid_d !== e_valid) begin errors++; $display("[TB] FAIL hold_ifid got %h %h %b want %h %h %b", pc_d, instr_d, valid_d, e_pcd, e_instr, e_valid); end
            imem_rdata = $urandom; npc = $urandom;
        end
        stall = 1'b0; imem_ack = 1'b0; npc = b + 32'd4;
        @(negedge clk);
        exp_pc = b + 32'd4; e_pcd = b; e_instr = word; e_valid = 1'b1; e_adel = 1'b0;
        checks++; if (instr_d !== word || pc_d !== b || valid_d !== 1'b1) begin errors++; $display("[TB] FAIL hold_release got %h %h %b want %h %h 1", instr_d, pc_d, valid_d, word, b); end
        checks++; if (pc_f !== exp_pc || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL hold_refetch got %h %b want %h 1", pc_f, imem_req, exp_pc); end
    endtask

    task automatic test_misaligned();
        logic [31:0] c;
        logic [31:0] word;
        c = exp_pc; word = $urandom;
        imem_ack = 1'b1; stall = 1'b0; imem_rdata = word; npc = c + 32'd2;
        @(negedge clk);
        checks++; if (pc_f !== c + 32'd2 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_noreq got %h %b want %h 0", pc_f, imem_req, c + 32'd2); end
        checks++; if (pc_d !== c || instr_d !== word) begin errors++; $display("[TB] FAIL mis_prev got %h %h want %h %h", pc_d, instr_d, c, word); end
        stall = 1'b1; imem_rdata = $urandom; npc = $urandom;
        @(negedge clk);
        checks++; if (pc_f !== c + 32'd2 || pc_d !== c || valid_d !== 1'b1 || adel_d !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_stall got %h %h %b %b %b", pc_f, pc_d, valid_d, adel_d, imem_req); end
        stall = 1'b0; npc = c + 32'd4;
        @(negedge clk);
        checks++; if (pc_d !== c + 32'd2 || adel_d !== 1'b1 || valid_d !== 1'b0 || instr_d !== NOP) begin errors++; $display("[TB] FAIL mis_fault got %h %b %b %h want %h 1 0 %h", pc_d, adel_d, valid_d, instr_d, c + 32'd2, NOP); end
        checks++; if (pc_f !== c + 32'd4 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL mis_next got %h %b want %h 1", pc_f, imem_req, c + 32'd4); end
        word = $urandom; imem_rdata = word; npc = c + 32'd8;
        @(negedge clk);
        checks++; if (adel_d !== 1'b0 || valid_d !== 1'b1 || pc_d !== c + 32'd4 || instr_d !== word) begin errors++; $display("[TB] FAIL mis_recover got %b %b %h %h", adel_d, valid_d, pc_d, instr_d); end
        exp_pc = c + 32'd8; e_pcd = c + 32'd4; e_instr = word; e_valid = 1'b1; e_adel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        d = exp_pc;
        imem_ack = 1'b0; stall = 1'b0; npc = $urandom;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== d) begin errors++; $display("[TB] FAIL mid_outstanding got %b %h want 1 %h", imem_req, imem_addr, d); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc_f !== PC_RST || pc_d !== 32'h0 || instr_d !== NOP || valid_d !== 1'b0 || adel_d !== 1'b0) begin errors++; $display("[TB] FAIL mid_async got %h %h %h %b %b", pc_f, pc_d, instr_d, valid_d, adel_d); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_req got %b want 0", imem_req); end
        imem_ack = 1'b1; imem_rdata = $urandom;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (valid_d !== 1'b0 || pc_d !== 32'h0 || pc_f !== PC_RST || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_late_ack got %b %h %h %b", valid_d, pc_d, pc_f, imem_req); end
        exp_pc = PC_RST; e_pcd = 32'h0; e_instr = NOP; e_valid = 1'b0; e_adel = 1'b0;
    endtask

    task automatic test_random();
        logic        buffered;
        logic [31:0] buf_word;
        logic        e_req;
        int          r;
        buffered = 1'b0; buf_word = 32'h0;
        for (int n = 0; n < 10000; n++) begin
            stall = ($urandom_range(0, 3) == 0);
            imem_ack = $urandom_range(0, 1);
            imem_rdata = $urandom;
            r = $urandom_range(0, 99);
            if (r < 75) npc = exp_pc + 32'd4;
            else if (r < 80) npc = 32'hFFFF_FFFC;
            else if (r < 93) npc = $urandom & 32'hFFFF_FFFC;
            else npc = $urandom | 32'h1;
            // Transaction view: a word is either delivered, parked, or the slot bubbles.
            if (buffered) begin
                if (!stall) begin
                    e_pcd = exp_pc; e_instr = buf_word; e_valid = 1'b1; e_adel = 1'b0;
                    exp_pc = npc; buffered = 1'b0;
                end
            end else if (exp_pc[1:0] != 2'b00) begin
                if (!stall) begin
                    e_pcd = exp_pc; e_instr = NOP; e_valid = 1'b0; e_adel = 1'b1;
                    exp_pc = npc;
                end
            end else if (imem_ack) begin
                if (!stall) begin
                    e_pcd = exp_pc; e_instr = imem_rdata; e_valid = 1'b1; e_adel = 1'b0;
                    exp_pc = npc;
                end else begin
                    buffered = 1'b1; buf_word = imem_rdata;
                end
            end else if (!stall) begin
                e_pcd = exp_pc; e_instr = NOP; e_valid = 1'b0; e_adel = 1'b0;
            end
            e_req = !buffered && (exp_pc[1:0] == 2'b00);
            @(negedge clk);
            checks++; if (pc_f !== exp_pc) begin errors++; $display("[TB] FAIL rnd_pc_f cyc %0d got %h want %h", n, pc_f, exp_pc); end
            checks++; if (imem_req !== e_req) begin errors++; $display("[TB] FAIL rnd_req cyc %0d got %b want %b", n, imem_req, e_req); end
            checks++; if (imem_addr !== exp_pc) begin errors++; $display("[TB] FAIL rnd_addr cyc %0d got %h want %h", n, imem_addr, exp_pc); end
            checks++; if (pc_d !== e_pcd || instr_d !== e_instr) begin errors++; $display("[TB] FAIL rnd_ifid cyc %0d got %h %h want %h %h", n, pc_d, instr_d, e_pcd, e_instr); end
            checks++; if (valid_d !== e_valid || adel_d !== e_adel) begin errors++; $display("[TB] FAIL rnd_flags cyc %0d got %b %b want %b %b", n, valid_d, adel_d, e_valid, e_adel); end
        end
    endtask

    initial begin
        rst_n = 1'b0; npc = 32'h0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_ack_delay();
        test_ack_stall();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
